// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF-stage fetches and MEM-stage loads/stores onto a
// single byte-wide synchronous RAM port. Each word access takes four byte
// cycles. Read bytes are assembled little-endian into the owner's data register.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   if_re/if_addr            fetch request and byte address
//   if_data/if_busy/if_done  fetched word, busy flag, completion pulse
//   ls_re/ls_we/ls_addr      load/store request (store wins) and byte address
//   ls_sel/ls_wdata          store byte-enables and little-endian store data
//   ls_data/ls_busy/ls_done  loaded word, busy flag, completion pulse
//   ram_addr/ram_din/ram_we  RAM byte address, write data, write strobe
//   ram_dout                 RAM read data, valid one cycle after ram_addr
module mem_ctrl #(
   parameter int unsigned ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_re,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_data,
   output logic              if_busy,
   output logic              if_done,
   input  logic              ls_re,
   input  logic              ls_we,
   input  logic [31:0]       ls_addr,
   input  logic [3:0]        ls_sel,
   input  logic [31:0]       ls_wdata,
   output logic [31:0]       ls_data,
   output logic              ls_busy,
   output logic              ls_done,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_dout,
   output logic [7:0]        ram_din,
   output logic              ram_we
);

   localparam int unsigned WA_W = ADDR_W - 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              owner_ls_q, owner_ls_d;
   logic [WA_W-1:0]   base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        sel_q, sel_d;
   logic              busy_q, busy_d;
   logic [31:0]       if_data_d, ls_data_d;
   logic [ADDR_W-1:0] ram_addr_d;
   logic [7:0]        ram_din_d;
   logic              ram_we_d, if_done_d, ls_done_d;
   logic [1:0]        byte_idx, nxt_idx;

   // Word-offset bits and bits above the RAM width are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:ADDR_W], if_addr[1:0],
                               ls_addr[31:ADDR_W], ls_addr[1:0]};

   assign if_busy = busy_q;
   assign ls_busy = busy_q;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         owner_ls_q <= 1'b0;
         base_q     <= '0;
         wdata_q    <= 32'd0;
         sel_q      <= 4'd0;
         busy_q     <= 1'b0;
         if_data    <= 32'd0;
         ls_data    <= 32'd0;
         if_done    <= 1'b0;
         ls_done    <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= 8'd0;
         ram_we     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_ls_q <= owner_ls_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         if_data    <= if_data_d;
         ls_data    <= ls_data_d;
         if_done    <= if_done_d;
         ls_done    <= ls_done_d;
         ram_addr   <= ram_addr_d;
         ram_din    <= ram_din_d;
         ram_we     <= ram_we_d;
      end
   end

   // Next state and next output values. RAM port values are computed one
   // cycle ahead so the registered port shows base+cnt during cycle cnt.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_ls_d = owner_ls_q;
      base_d     = base_q;
      wdata_d    = wdata_q;
      sel_d      = sel_q;
      busy_d     = 1'b0;
      if_data_d  = if_data;
      ls_data_d  = ls_data;
      if_done_d  = 1'b0;
      ls_done_d  = 1'b0;
      ram_addr_d = ram_addr;
      ram_din_d  = ram_din;
      ram_we_d   = 1'b0;
      byte_idx   = 2'(cnt_q - 3'd1);
      nxt_idx    = 2'(cnt_q + 3'd1);

      case (state_q)
         S_IDLE: begin
            if (ls_we) begin
               state_d    = S_WRITE;
               owner_ls_d = 1'b1;
               base_d     = ls_addr[ADDR_W-1:2];
               wdata_d    = ls_wdata;
               sel_d      = ls_sel;
               cnt_d      = 3'd0;
               busy_d     = 1'b1;
               ram_addr_d = {ls_addr[ADDR_W-1:2], 2'b00};
               ram_din_d  = ls_wdata[7:0];
               ram_we_d   = ls_sel[0];
            end else if (ls_re) begin
               state_d    = S_READ;
               owner_ls_d = 1'b1;
               base_d     = ls_addr[ADDR_W-1:2];
               cnt_d      = 3'd0;
               busy_d     = 1'b1;
               ram_addr_d = {ls_addr[ADDR_W-1:2], 2'b00};
            end else if (if_re) begin
               state_d    = S_READ;
               owner_ls_d = 1'b0;
               base_d     = if_addr[ADDR_W-1:2];
               cnt_d      = 3'd0;
               busy_d     = 1'b1;
               ram_addr_d = {if_addr[ADDR_W-1:2], 2'b00};
            end
         end

         S_READ: begin
            // ram_dout now carries the byte addressed in the previous cycle.
            if (cnt_q != 3'd0) begin
               if (owner_ls_q) ls_data_d[{byte_idx, 3'b000} +: 8] = ram_dout;
               else            if_data_d[{byte_idx, 3'b000} +: 8] = ram_dout;
            end
            if (cnt_q == 3'd4) begin
               state_d   = S_DONE;
               if_done_d = ~owner_ls_q;
               ls_done_d = owner_ls_q;
            end else begin
               cnt_d  = cnt_q + 3'd1;
               busy_d = 1'b1;
               if (cnt_q < 3'd3) ram_addr_d = {base_q, nxt_idx};
            end
         end

         S_WRITE: begin
            if (cnt_q == 3'd3) begin
               state_d   = S_DONE;
               if_done_d = ~owner_ls_q;
               ls_done_d = owner_ls_q;
            end else begin
               cnt_d      = cnt_q + 3'd1;
               busy_d     = 1'b1;
               ram_addr_d = {base_q, nxt_idx};
               ram_din_d  = wdata_q[{nxt_idx, 3'b000} +: 8];
               ram_we_d   = sel_q[nxt_idx];
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
